// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, FSM states,
// ULA operation codes and datapath mux selects.
package mc_pkg;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_R_WB,
        S_BRANCH,
        S_ADDI_EXEC,
        S_ADDI_WB,
        S_JUMP
    } state_t;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS
// datapath (slave).
interface mips_mc_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_op;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_operation;
    logic       instr_retired;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, branch_op, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, ula_operation, instr_retired, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, branch_op, pc_source, i_or_d,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, ula_operation, instr_retired, illegal_op
    );
endinterface

// File: rtl/mips_mc_control_perf_counter.sv
// Free-running enable counter with synchronous clear, wrapping at 2^WIDTH.
// Only present when MC_PERF_COUNTERS_EN is defined.
`ifdef MC_PERF_COUNTERS_EN
module mc_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
endmodule
`endif

// File: rtl/mips_mc_control.sv
// Moore sequencer stepping each MIPS instruction through fetch/decode/exec/mem/wb.
// MC_PERF_COUNTERS_EN adds cycle_count and instr_count outputs.
module mips_mc_control
    import mc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    mips_mc_control_if.master ctl
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  instr_count
`endif
);
    state_t r_state;
    state_t w_next;
    logic   w_retired;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        w_retired         = 1'b0;
        ctl.pc_write      = 1'b0;
        ctl.pc_write_cond = 1'b0;
        ctl.branch_op     = BR_NONE;
        ctl.pc_source     = PCSRC_ULA;
        ctl.i_or_d        = 1'b0;
        ctl.mem_read      = 1'b0;
        ctl.mem_write     = 1'b0;
        ctl.ir_write      = 1'b0;
        ctl.reg_dst       = 1'b0;
        ctl.mem_to_reg    = 1'b0;
        ctl.reg_write     = 1'b0;
        ctl.alu_src_a     = 1'b0;
        ctl.alu_src_b     = SRCB_RD2;
        ctl.ula_operation = ULA_ADD;
        ctl.illegal_op    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only latched once memory answers.
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                if (ctl.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    w_next       = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_SEXT_SH2;
                case (ctl.opcode)
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_R:           w_next = S_EXEC_R;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDI_EXEC;
                    OP_J:           w_next = S_JUMP;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        w_next         = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_SEXT;
                w_next        = (ctl.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                if (ctl.mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                w_retired      = 1'b1;
                w_next         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                if (ctl.mem_ready) begin
                    w_retired = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ctl.alu_src_a     = 1'b1;
                ctl.ula_operation = ULA_FUNCT;
                w_next            = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                w_retired     = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.ula_operation = ULA_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_TARGET;
                ctl.branch_op     = (ctl.opcode == OP_BNE) ? BR_NE : BR_EQ;
                w_retired         = 1'b1;
                w_next            = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_SEXT;
                w_next        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                w_retired     = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
                w_retired     = 1'b1;
                w_next        = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
        ctl.instr_retired = w_retired;
    end

`ifdef MC_PERF_COUNTERS_EN
    mc_perf_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .clear (reset),
        .en    (1'b1),
        .count (cycle_count)
    );

    mc_perf_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clock (clock),
        .clear (reset),
        .en    (w_retired),
        .count (instr_count)
    );
`endif
endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle sequencing controller for the MIPS core. It replaces the single-cycle opcode decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back cycles. This lets one shared memory port and one ULA serve the whole instruction. It drives the PC, instruction register, regfile, ULA, ula_control and branch-selector enables, and stalls on a memory-ready handshake.

## Interface
- No parameters; all encodings come from the shared package.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by the branch selector.
- branch_op  out  2  00 none, 01 beq, 10 bne.
- pc_source  out  2  00 ULA result, 01 branch target register, 10 jump address.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ULA out.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  load instruction register.
- reg_dst, mem_to_reg, reg_write  out  1 each  regfile controls.
- alu_src_a  out  1  0 = PC, 1 = ReadData1.
- alu_src_b  out  2  00 ReadData2, 01 constant 4, 10 sign-extend, 11 sign-extend<<2.
- ula_operation  out  3  000 add, 001 sub, 010 decode funct.
- instr_retired  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.

## Operation
- States:
  - IDLE: reset landing state, one cycle only.
  - FETCH, DECODE.
  - MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE.
  - EXEC_R, R_WB.
  - BRANCH.
  - ADDI_EXEC, ADDI_WB.
  - JUMP.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- IDLE: all outputs 0; always goes to FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ula_operation=000, pc_source=00.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1, then the FSM goes to DECODE.
  - While mem_ready=0 the FSM stays in FETCH, mem_read stays high, and ir_write/pc_write stay 0.
- DECODE: alu_src_a=0, alu_src_b=11, ula_operation=000 (computes the branch target).
  - Next state by opcode: lw/sw→MEM_ADDR, R→EXEC_R, beq/bne→BRANCH, addi→ADDI_EXEC, j→JUMP.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, no architectural write.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ula_operation=000. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready=1, then retires in that cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00, ula_operation=010.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires.
- BRANCH: alu_src_a=1, alu_src_b=00, ula_operation=001, pc_write_cond=1, pc_source=01, branch_op=01 (beq) or 10 (bne). Retires.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ula_operation=000.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires.
- JUMP: pc_write=1, pc_source=10. Retires.
- Every retiring state returns to FETCH.
- Outputs are a pure function of state, plus mem_ready in FETCH/MEM_WRITE and opcode in DECODE/BRANCH. No output is asserted outside the states listed above.

## Timing
- reset high at an edge puts the FSM in IDLE the next cycle, from any state.
  - A stalled memory access is abandoned: strobes drop the cycle after the edge.
  - With reset held, the FSM stays in IDLE and all outputs are 0.
- Reset values: every output is 0.
- Latency with mem_ready=1: R 4, lw 5, sw 4, beq/bne 3, addi 4, j 3 cycles, counted from FETCH entry. Each mem_ready=0 cycle adds one cycle.
- mem_ready is sampled only in FETCH, MEM_READ and MEM_WRITE; it is ignored elsewhere.
- instr_retired and illegal_op are never high in the same cycle.

## Configuration
- MC_PERF_COUNTERS_EN defined: adds two outputs.
  - cycle_count (out 32): counts every non-reset cycle.
  - instr_count (out 32): increments on instr_retired.
  - Both are 0 on reset and wrap from 0xFFFFFFFF to 0.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

## Structure
- Package mc_pkg holds the opcode constants, the state enum, the ula_operation codes, the alu_src_b / pc_source / branch_op codes, and the counter width.
- One sub-module, mc_perf_counter (a 32-bit enable counter with synchronous clear), is instantiated twice under the macro.

## Test plan
- R-type (opcode 000000), mem_ready=1 → FETCH, DECODE, EXEC_R, R_WB. reg_write=1 and reg_dst=1 in cycle 4; instr_retired in cycle 4.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ → 7 cycles total. mem_read held throughout the stall; mem_to_reg=1 in MEM_WB.
- bne (000101) → cycle 3 shows pc_write_cond=1, branch_op=10, pc_source=01, ula_operation=001.
- Opcode 111111 → illegal_op pulse in DECODE, FETCH next, no reg_write/mem_write at any point.
- reset asserted mid-MEM_WRITE stall → next cycle IDLE with all outputs 0, then FETCH.
- With MC_PERF_COUNTERS_EN: three j instructions (000010) after reset → instr_count=3, cycle_count=10 (including IDLE).
